hex_msg_scroller: RTL and testbench
===================================

// Module: hex_msg_scroller
// PURPOSE
//  Drives NUM_DIGITS seven-segment digits from a MSG_LEN-character message with three modes: STATIC, SCROLL and BLINK.
//  This is the parametrised successor of the fixed-pattern KEY-gated HEX driver.
//  Two push-buttons are debounced on-chip: one toggles run/pause, one steps the mode.
//  It sits between the board top level (KEY/HEX pins) and whatever logic supplies the message.
// PARAMETERS
//  NUM_DIGITS      6       number of HEX digits driven; >=1
//  MSG_LEN         16      message length in characters; >=1 (may be < NUM_DIGITS)
//  TICK_DIV        12500000 clk cycles per step tick (scroll/blink rate); >=2
//  DEBOUNCE_CYCLES 500000  consecutive stable samples required to accept a key level; >=1
//  ACTIVE_LOW      0       1 = invert every segment output (lit = 0)
// PORTS
//  clk       in   1               system clock
//  rst       in   1               asynchronous, active-high reset
//  KEY       in   2               raw push-buttons, pressed = 0; KEY[0] run/pause, KEY[1] mode
//  msg_data  in   5*MSG_LEN       char k at [5k+4:5k]; char 0 = leftmost
//  HEX       out  8*NUM_DIGITS    digit i at [8i+7:8i]; digit 0 = rightmost; bits {a,b,c,d,e,f,g,dp}, MSB = a
//  mode_o    out  2               0 = STATIC, 1 = SCROLL, 2 = BLINK
//  running_o out  1               1 = running, 0 = paused
//  step_o    out  1               one-cycle pulse on every step tick
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - mode = STATIC, running = 1, offset = 0, blink_phase = 1, tick_cnt = 0.
//   - Debounced keys = 1 (released). step_o = 0.
//   - HEX = all segments dark (0, or all-ones if ACTIVE_LOW).
//  Key path:
//   - Each KEY bit passes a 2-flop synchroniser, then a counter.
//   - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples differing from it.
//   - A press event is a 1-cycle pulse on the debounced 1->0 transition; release generates nothing.
//   - Glitches shorter than DEBOUNCE_CYCLES generate no event.
//  Tick:
//   - tick_cnt counts 0..TICK_DIV-1 continuously, including while paused.
//   - step_o = 1 in the cycle tick_cnt == TICK_DIV-1; the counter then wraps to 0.
//  Mode FSM (on a KEY[1] event): STATIC -> SCROLL -> BLINK -> STATIC.
//   - Entering STATIC forces offset = 0.
//   - Entering BLINK forces blink_phase = 1.
//   - Encoding 3 is unreachable; if ever held, the FSM recovers to STATIC next cycle.
//  Run/pause: a KEY[0] event toggles running.
//  Step effect (step_o && running && no mode event in the same cycle):
//   - SCROLL: offset = (offset == MSG_LEN-1) ? 0 : offset+1.
//   - BLINK: blink_phase toggles.
//   - STATIC: no effect.
//  Simultaneous events:
//   - Mode event + step in the same cycle: the mode event wins and the step is discarded.
//   - KEY[0] + KEY[1] events in the same cycle: both are applied.
//   - Pause in the same cycle as a step: the step still applies, using the pre-toggle running value.
//  Display mapping:
//   - Digit i shows char index (offset + NUM_DIGITS-1-i) mod MSG_LEN.
//   - The index wraps modulo MSG_LEN; if MSG_LEN < NUM_DIGITS, characters repeat.
//  Glyphs (lit=1, before ACTIVE_LOW):
//   - Codes 0-15 = hex 0-F, standard 7-seg (0=8'hFC, 1=8'h60, 7=8'hE0).
//   - Code 16 = blank (8'h00); code 17 = dash (8'h02); codes 18-31 = blank.
//   - dp is always 0.
//  Blink: in BLINK mode with blink_phase = 0, all digits are dark.
//  Outputs are registered:
//   - HEX reflects state/msg_data one cycle after they change (1-cycle latency).
//   - mode_o and running_o are the state registers directly.
//  Reset mid-operation: all state returns to reset values immediately; in-progress debounce counts are discarded.
// TESTING (bench params: NUM_DIGITS=6, MSG_LEN=8, TICK_DIV=4, DEBOUNCE_CYCLES=3, ACTIVE_LOW=0)
//  - Reset check: assert rst mid-run -> HEX=0 that cycle; after release mode_o=0, running_o=1.
//      Next cycle HEX5..HEX0 show chars 0..5; with msg = codes 0..7, HEX0 = 8'hB6 ('5').
//  - Debounce: KEY[1] low for 2 cycles -> no mode change.
//      KEY[1] low for 10 cycles -> exactly one change, mode_o = 1, within 2+3+2 cycles of the falling edge.
//  - Scroll wrap: SCROLL mode, run 8 ticks -> offset goes 1..7 then 0; at offset 7, HEX5 = char 7 and HEX4 = char 0.
//      Check step_o period = 4 cycles.
//  - Pause: KEY[0] press -> running_o = 0; 3 ticks -> HEX unchanged.
//      Second press -> running_o = 1; scrolling resumes from the held offset.
//  - Blink/mode cycle: enter BLINK -> HEX lit for 4 cycles, dark for 4, alternating.
//      Press KEY[1] in a step_o cycle -> mode_o = 0, offset = 0, that step is discarded.
//  - Glyphs/wrap: MSG_LEN=4 with codes {16,17,10,15} -> HEX5..0 = 00,02,EE,8E,00,02.
//      Re-run with ACTIVE_LOW=1 -> all bytes are inverted.

Source files
------------

// File: rtl/hex_msg_scroller.sv
// Seven-segment message scroller: debounced run/mode keys, tick generator, STATIC/SCROLL/BLINK
// display modes and a registered glyph output for NUM_DIGITS digits.
`timescale 1ns/1ps
module hex_msg_scroller #(
    parameter int unsigned NUM_DIGITS      = 6,
    parameter int unsigned MSG_LEN         = 16,
    parameter int unsigned TICK_DIV        = 12500000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                KEY,
    input  logic [5*MSG_LEN-1:0]      msg_data,
    output logic [8*NUM_DIGITS-1:0]   HEX,
    output logic [1:0]                mode_o,
    output logic                      running_o,
    output logic                      step_o
);

    localparam int unsigned OFF_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HEX_W  = 8 * NUM_DIGITS;

    typedef enum logic [1:0] {
        STATIC   = 2'd0,
        SCROLL   = 2'd1,
        BLINK    = 2'd2,
        BAD_MODE = 2'd3
    } mode_t;

    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            db_level;
    logic [1:0]            press;
    logic [1:0][DB_W-1:0]  db_cnt;
    logic [TICK_W-1:0]     tick_cnt;
    mode_t                 mode;
    logic                  running;
    logic [OFF_W-1:0]      offset;
    logic                  blink_phase;
    logic                  dark;
    logic [HEX_W-1:0]      hex_next;

    // Synchronise both keys, then accept a new level only after DEBOUNCE_CYCLES differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 2'b11;
            sync2    <= 2'b11;
            db_level <= 2'b11;
            press    <= 2'b00;
            db_cnt   <= '0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            press <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == db_level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level[k] <= sync2[k];
                    db_cnt[k]   <= '0;
                    press[k]    <= ~sync2[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    // step_o is registered so that it is high exactly while tick_cnt == TICK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            step_o   <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_W'(TICK_DIV - 1)) ? '0 : tick_cnt + TICK_W'(1);
            step_o   <= (tick_cnt == TICK_W'(TICK_DIV - 2));
        end
    end

    // Mode/run state: a mode event pre-empts any step landing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        <= STATIC;
            running     <= 1'b1;
            offset      <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (press[0]) begin
                running <= ~running;
            end
            if (mode == BAD_MODE) begin
                mode   <= STATIC;
                offset <= '0;
            end else if (press[1]) begin
                case (mode)
                    STATIC: mode <= SCROLL;
                    SCROLL: begin
                        mode        <= BLINK;
                        blink_phase <= 1'b1;
                    end
                    default: begin
                        mode   <= STATIC;
                        offset <= '0;
                    end
                endcase
            end else if (step_o && running) begin
                case (mode)
                    SCROLL:  offset <= (offset == OFF_W'(MSG_LEN - 1)) ? '0 : offset + OFF_W'(1);
                    BLINK:   blink_phase <= ~blink_phase;
                    default: ;
                endcase
            end
        end
    end

    assign mode_o    = mode;
    assign running_o = running;

    function automatic logic [7:0] glyph(input logic [4:0] code);
        case (code)
            5'd0:    glyph = 8'hFC;
            5'd1:    glyph = 8'h60;
            5'd2:    glyph = 8'hDA;
            5'd3:    glyph = 8'hF2;
            5'd4:    glyph = 8'h66;
            5'd5:    glyph = 8'hB6;
            5'd6:    glyph = 8'hBE;
            5'd7:    glyph = 8'hE0;
            5'd8:    glyph = 8'hFE;
            5'd9:    glyph = 8'hF6;
            5'd10:   glyph = 8'hEE;
            5'd11:   glyph = 8'h3E;
            5'd12:   glyph = 8'h9C;
            5'd13:   glyph = 8'h7A;
            5'd14:   glyph = 8'h9E;
            5'd15:   glyph = 8'h8E;
            5'd17:   glyph = 8'h02;
            default: glyph = 8'h00;
        endcase
    endfunction

    assign dark = (mode == BLINK) && !blink_phase;

    // Digit i shows message char (offset + NUM_DIGITS-1-i) mod MSG_LEN
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic [4:0] code;
        assign code = 5'(msg_data >> (5 * ((32'(offset) + (NUM_DIGITS - 1 - i)) % MSG_LEN)));
        assign hex_next[8*i +: 8] = dark ? 8'h00 : glyph(code);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HEX <= {HEX_W{ACTIVE_LOW}};
        end else begin
            HEX <= {HEX_W{ACTIVE_LOW}} ^ hex_next;
        end
    end

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Bench for hex_msg_scroller: glyph table vectors on MSG_LEN=4 copies, plus a cycle-level
// expected-state scoreboard for the MSG_LEN=8 copy covering debounce, scroll, pause and blink.
`timescale 1ns/1ps
module tb_hex_msg_scroller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  key = 2'b11;
    logic [1:0]  key_idle = 2'b11;
    logic [39:0] msg;
    logic [19:0] msg4;
    logic [47:0] hex, hex4, hex4n;
    logic [1:0]  mode, mode4, mode4n;
    logic        run, run4, run4n, step, step4, step4n;

    always #5 clk = ~clk;

    hex_msg_scroller #(.NUM_DIGITS(6), .MSG_LEN(8), .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .KEY(key), .msg_data(msg), .HEX(hex),
        .mode_o(mode), .running_o(run), .step_o(step));

    hex_msg_scroller #(.NUM_DIGITS(6), .MSG_LEN(4), .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .ACTIVE_LOW(1'b0)) dut4 (
        .clk(clk), .rst(rst), .KEY(key_idle), .msg_data(msg4), .HEX(hex4),
        .mode_o(mode4), .running_o(run4), .step_o(step4));

    hex_msg_scroller #(.NUM_DIGITS(6), .MSG_LEN(4), .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .ACTIVE_LOW(1'b1)) dut4n (
        .clk(clk), .rst(rst), .KEY(key_idle), .msg_data(msg4), .HEX(hex4n),
        .mode_o(mode4n), .running_o(run4n), .step_o(step4n));

    typedef struct {
        string       name;
        int          due;
        int          which;
        logic [47:0] exp;
    } sb_t;

    typedef struct {
        logic [19:0] msg;
        logic [47:0] exp;
    } vec_t;

    sb_t  q[$];
    vec_t vecs[5];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   ev_cyc[2];
    int   m_mode, m_off;
    bit   m_run, m_phase, st, mev, rev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] glyph(input logic [4:0] c);
        case (c)
            5'd0: return 8'hFC;  5'd1: return 8'h60;  5'd2: return 8'hDA;  5'd3: return 8'hF2;
            5'd4: return 8'h66;  5'd5: return 8'hB6;  5'd6: return 8'hBE;  5'd7: return 8'hE0;
            5'd8: return 8'hFE;  5'd9: return 8'hF6;  5'd10: return 8'hEE; 5'd11: return 8'h3E;
            5'd12: return 8'h9C; 5'd13: return 8'h7A; 5'd14: return 8'h9E; 5'd15: return 8'h8E;
            5'd17: return 8'h02;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [47:0] model_hex(input logic [39:0] m, input int off, input bit dark);
        logic [47:0] r;
        int          idx;
        r = '0;
        for (int i = 5; i >= 0; i--) begin
            idx = (off + 5 - i) % 8;
            r = {r[39:0], dark ? 8'h00 : glyph(5'(m >> (5 * idx)))};
        end
        return r;
    endfunction

    function automatic logic [47:0] got_of(input int which);
        case (which)
            0: return hex;
            1: return hex4;
            2: return hex4n;
            3: return {46'b0, mode};
            default: return {47'b0, run};
        endcase
    endfunction

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input string name, input int due, input int which, input logic [47:0] exp);
        sb_t e;
        e.name = name; e.due = due; e.which = which; e.exp = exp;
        q.push_back(e);
    endtask

    // Scoreboard drain, then advance the expected state for the MSG_LEN=8 copy
    always @(negedge clk) begin
        for (int j = q.size() - 1; j >= 0; j--) begin
            if (q[j].due == cyc) begin
                check(q[j].name, got_of(q[j].which), q[j].exp);
                q.delete(j);
            end else if (q[j].due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: expectation for cycle %0d was never compared", q[j].name, q[j].due);
                q.delete(j);
            end
        end
        if (rst) begin
            m_mode = 0; m_run = 1'b1; m_off = 0; m_phase = 1'b1;
        end else begin
            st = (((cyc - rel_cyc) % 4) == 3);
            check("step_o", {47'b0, step}, {47'b0, st});
            check("step_o_len4", {46'b0, step4, step4n}, {46'b0, st, st});
            mev = (cyc == ev_cyc[1]);
            rev = (cyc == ev_cyc[0]);
            if (mev) begin
                case (m_mode)
                    0: m_mode = 1;
                    1: begin m_mode = 2; m_phase = 1'b1; end
                    default: begin m_mode = 0; m_off = 0; end
                endcase
            end else if (st && m_run) begin
                if (m_mode == 1) m_off = (m_off + 1) % 8;
                else if (m_mode == 2) m_phase = ~m_phase;
            end
            if (rev) m_run = ~m_run;
            push("mode_o", cyc + 1, 3, 48'(m_mode));
            push("running_o", cyc + 1, 4, {47'b0, m_run});
            push("hex", cyc + 2, 0, model_hex(msg, m_off, (m_mode == 2) && !m_phase));
            if (m_mode == 1 && m_off == 7) push("hex_offset7_literal", cyc + 2, 0, 48'hE0FC60DAF266);
        end
    end

    task automatic press(input int k, input int len, input bit align);
        int guard = 0;
        @(posedge clk);
        #1;
        if (align) begin
            while ((((cyc + 5 - rel_cyc) % 4) != 3) && guard < 8) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 8) begin
                total++;
                bad++;
                $display("FAIL align_press: no step-aligned slot within 8 cycles");
            end
        end
        key[k] = 1'b0;
        if (len >= 3) ev_cyc[k] = cyc + 5;
        repeat (len) @(posedge clk);
        #1 key[k] = 1'b1;
    endtask

    task automatic press_both(input int len);
        @(posedge clk);
        #1;
        key = 2'b00;
        ev_cyc[0] = cyc + 5;
        ev_cyc[1] = cyc + 5;
        repeat (len) @(posedge clk);
        #1 key = 2'b11;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rel_cyc = cyc;
        push("post_reset_hex_literal", cyc + 1, 0, 48'hFC60DAF266B6);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) msg[5*k +: 5] = 5'(k);
        msg4 = {5'd15, 5'd10, 5'd17, 5'd16};
        ev_cyc = '{-100, -100};
        // chars c0..c3 at offset 0 appear as HEX5..HEX0 = c0,c1,c2,c3,c0,c1
        vecs[0] = '{{5'd15, 5'd10, 5'd17, 5'd16}, 48'h0002EE8E0002};
        vecs[1] = '{{5'd8,  5'd7,  5'd1,  5'd0},  48'hFC60E0FEFC60};
        vecs[2] = '{{5'd5,  5'd4,  5'd3,  5'd2},  48'hDAF266B6DAF2};
        vecs[3] = '{{5'd12, 5'd11, 5'd9,  5'd6},  48'hBEF63E9CBEF6};
        vecs[4] = '{{5'd31, 5'd18, 5'd14, 5'd13}, 48'h7A9E00007A9E};

        repeat (3) @(posedge clk);
        #1;
        check("reset_hex", hex, 48'h0);
        check("reset_hex_active_low", hex4n, {48{1'b1}});
        check("reset_mode", {46'b0, mode}, 48'h0);
        check("reset_running", {47'b0, run}, 48'h1);
        release_reset();

        for (int v = 0; v < 5; v++) begin
            @(posedge clk);
            #1;
            msg4 = vecs[v].msg;
            push($sformatf("glyph_vec%0d", v), cyc + 1, 1, vecs[v].exp);
            push($sformatf("glyph_vec%0d_active_low", v), cyc + 1, 2, ~vecs[v].exp);
        end
        repeat (3) @(posedge clk);

        press(1, 2, 1'b0);
        repeat (10) @(posedge clk);
        press(1, 10, 1'b0);
        repeat (14) @(posedge clk);

        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        ev_cyc = '{-100, -100};
        #1;
        check("midrun_reset_hex", hex, 48'h0);
        check("midrun_reset_mode", {46'b0, mode}, 48'h0);
        repeat (2) @(posedge clk);
        release_reset();
        repeat (4) @(posedge clk);

        press(1, 10, 1'b0);
        repeat (42) @(posedge clk);
        press(0, 5, 1'b0);
        repeat (16) @(posedge clk);
        press(0, 5, 1'b0);
        repeat (14) @(posedge clk);
        press(1, 5, 1'b0);
        repeat (22) @(posedge clk);
        press(1, 5, 1'b1);
        push("mode_wins_step_mode", ev_cyc[1] + 1, 3, 48'h0);
        push("mode_wins_step_hex", ev_cyc[1] + 2, 0, 48'hFC60DAF266B6);
        repeat (10) @(posedge clk);
        press_both(5);
        repeat (16) @(posedge clk);

        @(negedge clk);
        check("aux_mode_len4", {44'b0, mode4, mode4n}, 48'h0);
        check("aux_running_len4", {46'b0, run4, run4n}, 48'h3);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
